// File: rtl/decoder138_scan_if.sv
// Pin bundle for the clocked 3-to-8 decoder / scan strobe generator.
// valid qualifies Y_n and idx in the same cycle; there is no ready, so the consumer must take every valid cycle.
interface decoder138_scan_if;
  logic       G1;
  logic       G2A_n;
  logic       G2B_n;
  logic       mode;
  logic [2:0] sel;
  logic       load;
  logic [7:0] Y_n;
  logic [2:0] idx;
  logic       valid;
  logic       wrap;

  modport master (
    output G1, G2A_n, G2B_n, mode, sel, load,
    input  Y_n, idx, valid, wrap
  );

  modport slave (
    input  G1, G2A_n, G2B_n, mode, sel, load,
    output Y_n, idx, valid, wrap
  );
endinterface

// File: rtl/decoder138_scan.sv
// 74LS138-style decoder with registered active-low outputs, plus a scan mode that
// walks the outputs with a programmable dwell per index.
module decoder138_scan #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  decoder138_scan_if.slave  bus
);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  logic          en;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [7:0]    y_q, y_d;

  assign en = bus.G1 & ~bus.G2A_n & ~bus.G2B_n;

  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (!bus.mode) begin
      dwell_d = '0;
      if (en) begin
        idx_d   = bus.sel;
        valid_d = 1'b1;
      end
    end else if (en) begin
      valid_d = 1'b1;
      // load wins over an advance that falls due in the same cycle
      if (bus.load) begin
        idx_d   = bus.sel;
        dwell_d = '0;
      end else if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        idx_d   = idx_q + 3'd1;
        wrap_d  = (idx_q == 3'd7);
      end else begin
        dwell_d = dwell_q + CW'(1);
      end
    end
    // Y_n is derived from the next index so Y_n and idx always move together
    y_d = valid_d ? ~(8'b1 << idx_d) : 8'hFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 3'd0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      y_q     <= 8'hFF;
    end else begin
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign bus.Y_n   = y_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_decoder138_scan.sv
// Directed bench for decoder138_scan: a DWELL=4 and a DWELL=1 instance share stimulus,
// expectations are queued by the driver and compared by a separate monitor.
module tb_decoder138_scan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder138_scan_if if4();
  decoder138_scan_if if1();

  decoder138_scan #(.DWELL(4), .CW(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  decoder138_scan #(.DWELL(1), .CW(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  localparam logic [31:0] NOW = 32'hFFFF_FFFF;
  localparam logic [7:0] DTAB [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // entry: {dut(1=DWELL1), cycle tag, Y_n, idx, valid, wrap}
  logic [45:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  event        now_ev;

  function automatic logic [7:0] dec(input logic [2:0] i);
    return DTAB[i];
  endfunction

  task automatic set_in(input logic g1, input logic g2a, input logic g2b,
                        input logic m, input logic [2:0] s, input logic ld);
    if4.G1 = g1; if4.G2A_n = g2a; if4.G2B_n = g2b; if4.mode = m; if4.sel = s; if4.load = ld;
    if1.G1 = g1; if1.G2A_n = g2a; if1.G2B_n = g2b; if1.mode = m; if1.sel = s; if1.load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_next(input logic which, input string nm, input logic [7:0] y,
                             input logic [2:0] i, input logic v, input logic w);
    exp_q.push_back({which, cyc + 32'd1, y, i, v, w});
    name_q.push_back(nm);
  endtask

  task automatic expect_now(input logic which, input string nm, input logic [7:0] y,
                            input logic [2:0] i, input logic v, input logic w);
    exp_q.push_back({which, NOW, y, i, v, w});
    name_q.push_back(nm);
    -> now_ev;
    #1;
  endtask

  // monitor: compares queued expectations against the outputs of the tagged cycle
  always begin
    logic [45:0] e;
    logic [12:0] act;
    logic [31:0] tag;
    string       nm;
    @(negedge clk or now_ev);
    while (exp_q.size() > 0 && (exp_q[0][44:13] == NOW || exp_q[0][44:13] <= cyc)) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      tag = e[44:13];
      act = e[45] ? {if1.Y_n, if1.idx, if1.valid, if1.wrap}
                  : {if4.Y_n, if4.idx, if4.valid, if4.wrap};
      checks++;
      if (tag != NOW && tag != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d was never compared (now cycle %0d)", nm, tag, cyc);
      end else if (act != e[12:0]) begin
        errors++;
        $display("FAIL %s (cycle %0d): got y_n=%h idx=%0d valid=%b wrap=%b, want y_n=%h idx=%0d valid=%b wrap=%b",
                 nm, cyc, act[12:5], act[4:2], act[1], act[0], e[12:5], e[4:2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);

    // reset held with enables active
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_now(1'b0, "rst_hold4", 8'hFF, 3'd0, 1'b0, 1'b0);
      expect_now(1'b1, "rst_hold1", 8'hFF, 3'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    // scan from reset: edge n gives idx n/4 (DWELL=4) and n%8 (DWELL=1)
    for (int n = 1; n <= 43; n++) begin
      expect_next(1'b0, "scan4", dec(3'((n / 4) % 8)), 3'((n / 4) % 8), 1'b1, n == 32);
      if (n <= 20)
        expect_next(1'b1, "scan1", dec(3'(n % 8)), 3'(n % 8), 1'b1, (n % 8) == 0);
      tick();
    end

    // load at idx=2, dwell=3 overrides the due advance
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1);
    expect_next(1'b0, "load_over", 8'hBF, 3'd6, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    for (int n = 45; n <= 47; n++) begin
      expect_next(1'b0, "load_hold", 8'hBF, 3'd6, 1'b1, 1'b0);
      tick();
    end
    expect_next(1'b0, "load_adv", 8'h7F, 3'd7, 1'b1, 1'b0);
    tick();

    // run on to idx=4, dwell=1 (second wrap at edge 52)
    for (int n = 49; n <= 69; n++) begin
      if (n < 52)
        expect_next(1'b0, "scan4b", 8'h7F, 3'd7, 1'b1, 1'b0);
      else
        expect_next(1'b0, "scan4b", dec(3'((n - 52) / 4)), 3'((n - 52) / 4), 1'b1, n == 52);
      tick();
    end

    // freeze for 5 cycles, then the remaining 2 cycles of idx=4
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    for (int k = 0; k < 5; k++) begin
      expect_next(1'b0, "freeze", 8'hFF, 3'd4, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k < 2) expect_next(1'b0, "resume", 8'hEF, 3'd4, 1'b1, 1'b0);
      else       expect_next(1'b0, "resume_adv", 8'hDF, 3'd5, 1'b1, 1'b0);
      tick();
    end

    // scan -> direct with sel=3
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
    expect_next(1'b0, "to_direct4", 8'hF7, 3'd3, 1'b1, 1'b0);
    expect_next(1'b1, "to_direct1", 8'hF7, 3'd3, 1'b1, 1'b0);
    tick();

    // direct sweep
    for (int s = 0; s < 8; s++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'(s), 1'b0);
      expect_next(1'b0, "direct4", DTAB[s], 3'(s), 1'b1, 1'b0);
      expect_next(1'b1, "direct1", DTAB[s], 3'(s), 1'b1, 1'b0);
      tick();
    end

    // enable gating, one input at a time; idx must hold while sel moves
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
    expect_next(1'b0, "gate_on", 8'hDF, 3'd5, 1'b1, 1'b0);
    tick();
    for (int p = 0; p < 3; p++) begin
      set_in(p != 0, p == 1, p == 2, 1'b0, 3'd1, 1'b0);
      expect_next(1'b0, "gate_off", 8'hFF, 3'd5, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0);
      expect_next(1'b0, "gate_restore", 8'hDF, 3'd5, 1'b1, 1'b0);
      tick();
    end

    // load has no effect in direct mode
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
    expect_next(1'b0, "direct_load", 8'hFB, 3'd2, 1'b1, 1'b0);
    tick();

    // direct -> scan starts at idx=2 with a fresh dwell
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) expect_next(1'b0, "to_scan", 8'hFB, 3'd2, 1'b1, 1'b0);
      else       expect_next(1'b0, "to_scan_adv", 8'hF7, 3'd3, 1'b1, 1'b0);
      tick();
    end
    tick();

    // asynchronous reset mid-scan, between clock edges
    #1;
    rst_n = 1'b0;
    #1;
    expect_now(1'b0, "async_rst4", 8'hFF, 3'd0, 1'b0, 1'b0);
    expect_now(1'b1, "async_rst1", 8'hFF, 3'd0, 1'b0, 1'b0);
    tick();
    expect_now(1'b0, "rst_stay4", 8'hFF, 3'd0, 1'b0, 1'b0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
